// File: rtl/fb_access_arbiter_if.sv
// Bus bundle between the frame-buffer arbiter, the VGA timing source, the host
// write port, the clear controls and the single-port frame RAM.
interface fb_access_arbiter_if #(
  parameter int unsigned WIDTH_BITS  = 10,
  parameter int unsigned HEIGHT_BITS = 9,
  parameter int unsigned PIXEL_BITS  = 12
);
  // Scan-out side
  logic                              video_on_in;
  logic [WIDTH_BITS-1:0]             pixel_x_in;
  logic [HEIGHT_BITS-1:0]            pixel_y_in;
  logic [PIXEL_BITS-1:0]             pixel_out;
  // Host pixel-write port
  logic                              wr_req_in;
  logic [WIDTH_BITS-1:0]             wr_x_in;
  logic [HEIGHT_BITS-1:0]            wr_y_in;
  logic [PIXEL_BITS-1:0]             wr_data_in;
  logic                              wr_ack_out;
  // Clear engine controls
  logic                              clear_start_in;
  logic [PIXEL_BITS-1:0]             clear_color_in;
  logic                              clear_busy_out;
  logic                              clear_done_out;
  // Frame RAM port
  logic [WIDTH_BITS+HEIGHT_BITS-1:0] mem_addr_out;
  logic                              mem_we_out;
  logic [PIXEL_BITS-1:0]             mem_wdata_out;
  logic [PIXEL_BITS-1:0]             mem_rdata_in;

  // Arbiter side
  modport slave (
    input  video_on_in, pixel_x_in, pixel_y_in,
    output pixel_out,
    input  wr_req_in, wr_x_in, wr_y_in, wr_data_in,
    output wr_ack_out,
    input  clear_start_in, clear_color_in,
    output clear_busy_out, clear_done_out,
    output mem_addr_out, mem_we_out, mem_wdata_out,
    input  mem_rdata_in
  );

  // Environment side: sync generator, host, RAM
  modport master (
    output video_on_in, pixel_x_in, pixel_y_in,
    input  pixel_out,
    output wr_req_in, wr_x_in, wr_y_in, wr_data_in,
    input  wr_ack_out,
    output clear_start_in, clear_color_in,
    input  clear_busy_out, clear_done_out,
    input  mem_addr_out, mem_we_out, mem_wdata_out,
    output mem_rdata_in
  );
endinterface

// File: rtl/fb_access_arbiter.sv
// Single-port frame-buffer arbiter: scan-out owns active video, the clear engine
// and host writes share blanking cycles with the clear taking priority.
module fb_access_arbiter #(
  parameter int unsigned WIDTH       = 640,
  parameter int unsigned HEIGHT      = 480,
  parameter int unsigned WIDTH_BITS  = 10,
  parameter int unsigned HEIGHT_BITS = 9,
  parameter int unsigned PIXEL_BITS  = 12
) (
  input  logic                clock_in,
  input  logic                reset_in,
  fb_access_arbiter_if.slave  bus
);

  typedef enum logic [0:0] {StIdle, StClear} clear_state_e;

  clear_state_e           state_q, state_d;
  logic [WIDTH_BITS-1:0]  cx_q, cx_d;
  logic [HEIGHT_BITS-1:0] cy_q, cy_d;
  logic [PIXEL_BITS-1:0]  color_q, color_d;
  logic                   done_q, done_d;
  logic                   vid_d1_q;
  logic [PIXEL_BITS-1:0]  pixel_q;

  logic [WIDTH_BITS+HEIGHT_BITS-1:0] mem_addr;
  logic                              mem_we;
  logic [PIXEL_BITS-1:0]             mem_wdata;
  logic                              wr_ack;

  logic cx_last, cy_last, wr_in_range;

  assign cx_last     = (32'(cx_q) == WIDTH - 1);
  assign cy_last     = (32'(cy_q) == HEIGHT - 1);
  assign wr_in_range = (32'(bus.wr_x_in) < WIDTH) && (32'(bus.wr_y_in) < HEIGHT);

  always_comb begin
    state_d   = state_q;
    cx_d      = cx_q;
    cy_d      = cy_q;
    color_d   = color_q;
    done_d    = 1'b0;
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    wr_ack    = 1'b0;

    // Clear sequencing; the sweep only advances on cycles it actually wrote.
    unique case (state_q)
      StIdle: begin
        if (bus.clear_start_in) begin
          state_d = StClear;
          cx_d    = '0;
          cy_d    = '0;
          color_d = bus.clear_color_in;
        end
      end
      StClear: begin
        if (!bus.video_on_in) begin
          if (cx_last && cy_last) begin
            state_d = StIdle;
            cx_d    = '0;
            cy_d    = '0;
            done_d  = 1'b1;
          end else if (cx_last) begin
            cx_d = '0;
            cy_d = cy_q + 1'b1;
          end else begin
            cx_d = cx_q + 1'b1;
          end
        end
      end
      default: ;
    endcase

    // Fixed-priority port grant: scan read, clear write, host write.
    if (bus.video_on_in) begin
      mem_addr = {bus.pixel_y_in, bus.pixel_x_in};
    end else if (state_q == StClear) begin
      mem_addr  = {cy_q, cx_q};
      mem_we    = 1'b1;
      mem_wdata = color_q;
    end else if (bus.wr_req_in) begin
      mem_addr  = {bus.wr_y_in, bus.wr_x_in};
      mem_wdata = bus.wr_data_in;
      mem_we    = wr_in_range;
      wr_ack    = 1'b1;
    end

    // Grant outputs are combinational, so hold them quiet during reset.
    if (!reset_in) begin
      mem_addr  = '0;
      mem_we    = 1'b0;
      mem_wdata = '0;
      wr_ack    = 1'b0;
    end
  end

  always_ff @(posedge clock_in) begin
    if (!reset_in) begin
      state_q  <= StIdle;
      cx_q     <= '0;
      cy_q     <= '0;
      color_q  <= '0;
      done_q   <= 1'b0;
      vid_d1_q <= 1'b0;
      pixel_q  <= '0;
    end else begin
      state_q  <= state_d;
      cx_q     <= cx_d;
      cy_q     <= cy_d;
      color_q  <= color_d;
      done_q   <= done_d;
      vid_d1_q <= bus.video_on_in;
      pixel_q  <= vid_d1_q ? bus.mem_rdata_in : '0;
    end
  end

  assign bus.mem_addr_out   = mem_addr;
  assign bus.mem_we_out     = mem_we;
  assign bus.mem_wdata_out  = mem_wdata;
  assign bus.wr_ack_out     = wr_ack;
  assign bus.clear_busy_out = (state_q == StClear);
  assign bus.clear_done_out = done_q;
  assign bus.pixel_out      = pixel_q;

endmodule

// File: tb/tb_fb_access_arbiter.sv
// Randomised bench for fb_access_arbiter on a 4x2 screen, checked every cycle
// against a linear-index reference model and a shadow copy of the frame RAM.
module tb_fb_access_arbiter;
  localparam int unsigned W     = 4;
  localparam int unsigned H     = 2;
  localparam int unsigned WB    = 3;
  localparam int unsigned HB    = 3;
  localparam int unsigned PB    = 12;
  localparam int unsigned AW    = WB + HB;
  localparam int unsigned DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fb_access_arbiter_if #(.WIDTH_BITS(WB), .HEIGHT_BITS(HB), .PIXEL_BITS(PB)) bus ();

  fb_access_arbiter #(
    .WIDTH(W), .HEIGHT(H), .WIDTH_BITS(WB), .HEIGHT_BITS(HB), .PIXEL_BITS(PB)
  ) dut (
    .clock_in (clk),
    .reset_in (rst_n),
    .bus      (bus)
  );

  // Frame RAM seen by the DUT: synchronous write, 1-cycle registered read.
  logic [PB-1:0] ram [DEPTH];
  always @(posedge clk) begin
    if (bus.mem_we_out) ram[bus.mem_addr_out] <= bus.mem_wdata_out;
    bus.mem_rdata_in <= ram[bus.mem_addr_out];
  end

  // Reference model state
  logic [PB-1:0] shadow [DEPTH];
  bit            m_busy = 1'b0;
  bit            m_done = 1'b0;
  int            m_idx = 0;
  logic [PB-1:0] m_color = '0;
  logic [PB-1:0] m_pix = '0;
  logic [PB-1:0] m_rd = '0;
  bit            m_vid1 = 1'b0;
  bit            m_last_ack = 1'b0;

  int n_checks = 0;
  int n_pass = 0;
  int clear_writes = 0;
  int done_pulses = 0;
  int dp_snap;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Called at a negedge with this cycle's inputs applied; returns at the next negedge.
  task automatic cycle();
    logic [AW-1:0] e_addr;
    logic [PB-1:0] e_wdata;
    bit            e_we;
    bit            e_ack;
    #2;
    e_addr = '0; e_wdata = '0; e_we = 1'b0; e_ack = 1'b0;
    if (rst_n) begin
      if (bus.video_on_in) begin
        e_addr = {bus.pixel_y_in, bus.pixel_x_in};
      end else if (m_busy) begin
        e_addr  = {HB'(m_idx / W), WB'(m_idx % W)};
        e_we    = 1'b1;
        e_wdata = m_color;
      end else if (bus.wr_req_in) begin
        e_addr  = {bus.wr_y_in, bus.wr_x_in};
        e_wdata = bus.wr_data_in;
        e_ack   = 1'b1;
        e_we    = (int'(bus.wr_x_in) < W) && (int'(bus.wr_y_in) < H);
      end
    end
    check("wr_ack", 32'(bus.wr_ack_out), 32'(e_ack));
    check("mem_we", 32'(bus.mem_we_out), 32'(e_we));
    check("mem_addr", 32'(bus.mem_addr_out), 32'(e_addr));
    if (e_we) check("mem_wdata", 32'(bus.mem_wdata_out), 32'(e_wdata));
    check("clear_busy", 32'(bus.clear_busy_out), 32'(m_busy));
    check("clear_done", 32'(bus.clear_done_out), 32'(m_done));
    check("pixel", 32'(bus.pixel_out), 32'(m_pix));
    if (bus.clear_done_out) done_pulses++;
    if (bus.mem_we_out && !bus.wr_ack_out) clear_writes++;

    if (!rst_n) begin
      m_busy = 1'b0; m_done = 1'b0; m_idx = 0; m_pix = '0; m_vid1 = 1'b0;
    end else begin
      m_pix = m_vid1 ? m_rd : '0;
      if (bus.video_on_in) m_rd = shadow[e_addr];
      m_vid1 = bus.video_on_in;
      m_done = 1'b0;
      if (m_busy) begin
        if (!bus.video_on_in) begin
          if (m_idx == W * H - 1) begin
            m_busy = 1'b0;
            m_done = 1'b1;
          end else begin
            m_idx++;
          end
        end
      end else if (bus.clear_start_in) begin
        m_busy  = 1'b1;
        m_idx   = 0;
        m_color = bus.clear_color_in;
      end
    end
    if (e_we) shadow[e_addr] = e_wdata;
    m_last_ack = e_ack;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic new_req();
    bus.wr_req_in  = 1'b1;
    bus.wr_x_in    = WB'($urandom_range(0, 5));
    bus.wr_y_in    = HB'($urandom_range(0, 2));
    bus.wr_data_in = PB'($urandom);
  endtask

  initial begin
    bus.video_on_in = 1'b0; bus.pixel_x_in = '0; bus.pixel_y_in = '0;
    bus.wr_req_in = 1'b0; bus.wr_x_in = '0; bus.wr_y_in = '0; bus.wr_data_in = '0;
    bus.clear_start_in = 1'b0; bus.clear_color_in = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ram[i] = PB'($urandom);
      shadow[i] = ram[i];
    end
    ram[{3'd5, 3'd3}] = 12'hABC;
    shadow[{3'd5, 3'd3}] = 12'hABC;

    // Reset
    @(posedge clk);
    @(negedge clk);
    cycle();
    cycle();
    rst_n = 1'b1;

    // Scan read of {5,3}, then the same coordinate while blanked
    bus.video_on_in = 1'b1; bus.pixel_x_in = 3'd3; bus.pixel_y_in = 3'd5;
    cycle();
    bus.video_on_in = 1'b0;
    cycle();
    check("scan_abc", 32'(bus.pixel_out), 32'h0ABC);
    cycle();
    cycle();
    check("scan_blank", 32'(bus.pixel_out), 32'h0);

    // Host write held through active video
    bus.wr_req_in = 1'b1; bus.wr_x_in = 3'd2; bus.wr_y_in = 3'd1; bus.wr_data_in = 12'h0F0;
    bus.video_on_in = 1'b1;
    repeat (4) cycle();
    bus.video_on_in = 1'b0;
    #1 check("wr_first_blank_ack", 32'(bus.wr_ack_out), 32'h1);
    cycle();
    bus.wr_req_in = 1'b0;
    cycle();

    // Out-of-range write: acked and dropped
    bus.wr_req_in = 1'b1; bus.wr_x_in = 3'd4; bus.wr_y_in = 3'd0; bus.wr_data_in = 12'hEEE;
    #1 check("oor_ack", 32'(bus.wr_ack_out), 32'h1);
    check("oor_we", 32'(bus.mem_we_out), 32'h0);
    cycle();
    bus.wr_req_in = 1'b0;

    // Full clear with 3 active / 5 blank duty and a host write held off
    bus.clear_start_in = 1'b1; bus.clear_color_in = 12'h123;
    cycle();
    bus.clear_start_in = 1'b0;
    bus.wr_req_in = 1'b1; bus.wr_x_in = 3'd1; bus.wr_y_in = 3'd0; bus.wr_data_in = 12'h555;
    clear_writes = 0; done_pulses = 0;
    for (int c = 0; c < 40; c++) begin
      bus.video_on_in = (c % 8) < 3;
      cycle();
      if (m_last_ack) bus.wr_req_in = 1'b0;
    end
    check("clear_writes", 32'(clear_writes), 32'd8);
    check("clear_done_pulses", 32'(done_pulses), 32'd1);
    check("clear_px_1_1", 32'(ram[{3'd1, 3'd1}]), 32'h123);
    check("clear_px_0_3", 32'(ram[{3'd0, 3'd3}]), 32'h123);
    check("host_after_clear", 32'(ram[{3'd0, 3'd1}]), 32'h555);
    check("x_beyond_width", 32'(ram[{3'd0, 3'd4}]), 32'(shadow[{3'd0, 3'd4}]));

    // Reset after three clear writes aborts without a done pulse
    bus.video_on_in = 1'b0;
    bus.clear_start_in = 1'b1; bus.clear_color_in = 12'h7E7;
    cycle();
    bus.clear_start_in = 1'b0;
    repeat (3) cycle();
    dp_snap = done_pulses;
    rst_n = 1'b0;
    #1 check("rst_we", 32'(bus.mem_we_out), 32'h0);
    cycle();
    rst_n = 1'b1;
    repeat (3) cycle();
    check("no_done_after_rst", 32'(done_pulses), 32'(dp_snap));
    bus.clear_start_in = 1'b1; bus.clear_color_in = 12'h2A2;
    cycle();
    bus.clear_start_in = 1'b0;
    #1 check("restart_addr", 32'(bus.mem_addr_out), 32'h0);
    repeat (10) cycle();

    // Start and host request together, then a start while busy
    bus.wr_req_in = 1'b1; bus.wr_x_in = 3'd3; bus.wr_y_in = 3'd1; bus.wr_data_in = 12'hABD;
    bus.clear_start_in = 1'b1; bus.clear_color_in = 12'h321;
    #1 check("sim_ack", 32'(bus.wr_ack_out), 32'h1);
    cycle();
    bus.clear_start_in = 1'b0; bus.wr_req_in = 1'b0;
    cycle();
    bus.clear_start_in = 1'b1; bus.clear_color_in = 12'hFFF;
    cycle();
    bus.clear_start_in = 1'b0;
    repeat (12) cycle();

    // Randomised traffic
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 3) == 0) bus.video_on_in = ~bus.video_on_in;
      bus.pixel_x_in = WB'($urandom);
      bus.pixel_y_in = HB'($urandom);
      if (!bus.wr_req_in) begin
        if ($urandom_range(0, 2) == 0) new_req();
      end else if (m_last_ack) begin
        if ($urandom_range(0, 1) == 0) new_req();
        else bus.wr_req_in = 1'b0;
      end
      bus.clear_start_in = ($urandom_range(0, 59) == 0);
      bus.clear_color_in = PB'($urandom);
      rst_n = ($urandom_range(0, 399) != 0);
      cycle();
    end
    rst_n = 1'b1;
    bus.wr_req_in = 1'b0; bus.clear_start_in = 1'b0; bus.video_on_in = 1'b0;
    cycle();

    for (int i = 0; i < DEPTH; i++) check("ram_final", 32'(ram[i]), 32'(shadow[i]));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/fb_access_arbiter.md
# fb_access_arbiter

Shares the single-port frame-buffer RAM between the VGA scan-out reader, a host pixel-write port and a built-in full-screen clear engine. Sits between the VGA sync generator (which supplies `video_on_in` and the scan coordinates) and the frame RAM. Scan-out owns the port during active video; host writes and clear sweeps use blanking cycles only. Addressing is `{y, x}`, the same packing the frame-capture path uses.

## Interface
- `WIDTH`, 640, visible pixels per line
- `HEIGHT`, 480, visible lines per frame
- `WIDTH_BITS`, 10, x coordinate width
- `HEIGHT_BITS`, 9, y coordinate width
- `PIXEL_BITS`, 12, pixel word width
- `clock_in`  in  1  pixel clock; all logic on rising edge
- `reset_in`  in  1  synchronous, active-low reset
- `video_on_in`  in  1  active-video flag from the sync generator
- `pixel_x_in`  in  WIDTH_BITS  current scan x
- `pixel_y_in`  in  HEIGHT_BITS  current scan y
- `pixel_out`  out  PIXEL_BITS  registered pixel to DAC; 0 when blanked
- `wr_req_in`  in  1  host write request; held until acked
- `wr_x_in`  in  WIDTH_BITS  host write x
- `wr_y_in`  in  HEIGHT_BITS  host write y
- `wr_data_in`  in  PIXEL_BITS  host write pixel
- `wr_ack_out`  out  1  one-cycle ack; the write completes in this cycle
- `clear_start_in`  in  1  start full-screen clear (pulse)
- `clear_color_in`  in  PIXEL_BITS  fill colour, sampled with start
- `clear_busy_out`  out  1  high while a clear is in progress
- `clear_done_out`  out  1  one-cycle pulse after the last clear write
- `mem_addr_out`  out  WIDTH_BITS+HEIGHT_BITS  RAM address `{y, x}`
- `mem_we_out`  out  1  RAM write enable
- `mem_wdata_out`  out  PIXEL_BITS  RAM write data
- `mem_rdata_in`  in  PIXEL_BITS  RAM read data, 1-cycle latency

## Operation
- Clear FSM states: IDLE and CLEAR.
  - IDLE -> CLEAR on `clear_start_in`: latch the colour and set counters cx = 0, cy = 0.
  - CLEAR -> IDLE after the write to (WIDTH-1, HEIGHT-1).
  - `clear_start_in` while in CLEAR is ignored.
- Per-cycle grant, fixed priority. The memory outputs are combinational from state and inputs.
  1. `video_on_in` = 1: scan read.
     - `mem_addr_out` = `{pixel_y_in, pixel_x_in}`, `mem_we_out` = 0.
     - The host and clear engine wait.
  2. Blanking and state CLEAR: clear write.
     - `mem_addr_out` = `{cy, cx}`, `mem_wdata_out` = latched colour, `mem_we_out` = 1.
     - Then advance the counters: cx++, and when cx = WIDTH-1, set cx = 0 and cy++.
     - Host writes stall for the whole clear.
  3. Blanking, IDLE and `wr_req_in`: host write.
     - `mem_addr_out` = `{wr_y_in, wr_x_in}`, `mem_wdata_out` = `wr_data_in`, `wr_ack_out` = 1.
     - `mem_we_out` = 1 only if `wr_x_in` < WIDTH and `wr_y_in` < HEIGHT. An out-of-range request is acked and dropped.
  4. Otherwise: `mem_we_out` = 0 and `mem_addr_out` = 0.
- Host handshake:
  - `wr_req_in`, coordinates and data stay stable until the ack cycle.
  - After an ack, the host may hold `wr_req_in` high with new data for back-to-back writes, one per blanking cycle.
- The clear engine writes only the visible WIDTH×HEIGHT region. Addresses with x ≥ WIDTH are never touched.
- Scan-out:
  - `vid_d1` is `video_on_in` registered.
  - `pixel_out` is registered: `pixel_out` <= `vid_d1` ? `mem_rdata_in` : 0.

## Timing
- Reset while `reset_in` = 0:
  - `pixel_out` = 0, `wr_ack_out` = 0, `clear_busy_out` = 0, `clear_done_out` = 0, `mem_we_out` = 0, `mem_addr_out` = 0.
  - FSM = IDLE, counters = 0, `vid_d1` = 0.
- Reset mid-clear aborts the clear: no done pulse, RAM contents stay partially filled.
- Scan latency: a coordinate presented in cycle N appears on `pixel_out` in cycle N+2.
- Clear latency:
  - `clear_busy_out` rises the cycle after the start pulse.
  - A clear needs WIDTH×HEIGHT blanking cycles. Elapsed time depends on the blanking duty.
  - `clear_done_out` pulses in the cycle after the final write, in which `clear_busy_out` is already 0.
- Simultaneous start and host request in IDLE during blanking: the host write is granted that cycle, and the clear begins next cycle.
- Host request arriving when `video_on_in` falls: granted in the first blanking cycle, with zero-cycle grant latency.

## Test plan
- Scan read:
  - Stimulus: preload RAM[{5,3}] = 12'hABC; drive x = 3, y = 5, `video_on_in` = 1 in cycle N.
  - Response: `pixel_out` = 12'hABC in cycle N+2. With `video_on_in` = 0 in N, `pixel_out` = 0 in N+2.
- Host write during active video:
  - Stimulus: `wr_req_in` with (10,20,12'h0F0) held through 4 active cycles, then blanking.
  - Response: no ack and `mem_we_out` = 0 while active; ack and write to address {20,10} in the first blanking cycle.
- Out-of-range write:
  - Stimulus: (640,0) during blanking.
  - Response: `wr_ack_out` = 1, `mem_we_out` = 0.
- Clear with reduced size:
  - Stimulus: WIDTH = 4, HEIGHT = 2, alternating 3 active / 5 blank cycles, start colour 12'h123.
  - Response: exactly 8 writes at {0,0}..{0,3},{1,0}..{1,3}, one `clear_done_out` pulse, host held off until done.
- Reset mid-clear:
  - Stimulus: after 3 writes, assert `reset_in` = 0 for 1 cycle.
  - Response: all outputs 0, no done pulse; a new start restarts at {0,0}.
- Simultaneous events:
  - Stimulus: `clear_start_in` and `wr_req_in` in the same blanking cycle, or a start while busy.
  - Response: the host write is acked first and the clear follows. A start while busy changes neither the colour nor the counters.
